// File: rtl/led_sequencer.sv
// led_sequencer: Avalon-MM LED sequencer (direct/blink/chase/level-meter modes).
// Define LED_SEQ_PWM_EN to add a 16-step duty-cycle dimmer driven by CTRL[7:4].
module led_sequencer #(
  parameter int LED_W    = 10,
  parameter int PERIOD_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [15:0]       level_in,
  input  logic              level_valid,
  output logic [LED_W-1:0]  out_port
);
  localparam int PW = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam int HW = $clog2(LED_W + 1);
  typedef enum logic [2:0] {DIRECT, BLINK_ON, BLINK_OFF, CHASE, LEVEL} state_t;
  state_t              state, state_nx;
  logic [LED_W-1:0]    data_r, raw, out_nx;
  logic [3:0]          ctrl_lo, duty;
  logic [PERIOD_W-1:0] period_r, presc, presc_nx;
  logic [PW-1:0]       pos, pos_nx;
  logic [HW-1:0]       held, held_nx, held_lvl, dec, base, n_sat;
  logic [13:0]         prod;
  logic                wr, wr_data, wr_ctrl, wr_period, tick, pwm_on, unused_bits;
  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr && address == 2'd0;
  assign wr_ctrl   = wr && address == 2'd1;
  assign wr_period = wr && address == 2'd2;
  assign tick      = presc == '0;
  assign presc_nx  = wr_period ? writedata[PERIOD_W-1:0] : (wr_ctrl || tick) ? period_r : presc - 1'b1;
  // Level scaling: top 10 bits * 11 / 1024 maps full scale onto 0..10 LEDs.
  assign prod      = {4'b0, level_in[15:6]} * 14'd11;
  assign n_sat     = (32'(prod[13:10]) > LED_W) ? HW'(LED_W) : HW'(prod[13:10]);
  assign dec       = (held == '0) ? '0 : held - 1'b1;
  assign base      = tick ? dec : held;
  assign held_lvl  = (level_valid && n_sat > base) ? n_sat : base;
  assign unused_bits = ^{writedata, level_in[5:0]};
  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    held_nx  = held;
    raw      = data_r;
    case (state)
      BLINK_ON: state_nx = tick ? BLINK_OFF : BLINK_ON;
      BLINK_OFF: begin
        raw      = '0;
        state_nx = tick ? BLINK_ON : BLINK_OFF;
      end
      CHASE: begin
        raw = LED_W'(1) << pos;
        if (tick)
          pos_nx = ctrl_lo[2] ? ((pos == '0) ? PW'(LED_W - 1) : pos - 1'b1)
                              : ((pos == PW'(LED_W - 1)) ? '0 : pos + 1'b1);
      end
      LEVEL: begin
        raw     = ~({LED_W{1'b1}} << held);
        held_nx = held_lvl;
      end
      default: raw = data_r;
    endcase
    if (wr_ctrl) begin
      state_nx = (writedata[1:0] == 2'd0) ? DIRECT :
                 (writedata[1:0] == 2'd1) ? BLINK_ON :
                 (writedata[1:0] == 2'd2) ? CHASE : LEVEL;
      pos_nx   = '0;
      held_nx  = '0;
    end
    out_nx = raw & {LED_W{pwm_on}};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DIRECT;
      data_r   <= '1;
      ctrl_lo  <= '0;
      period_r <= PERIOD_W'(5_000_000);
      presc    <= PERIOD_W'(5_000_000);
      pos      <= '0;
      held     <= '0;
      out_port <= '1;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      pos      <= pos_nx;
      held     <= held_nx;
      out_port <= out_nx;
      if (wr_data)   data_r   <= writedata[LED_W-1:0];
      if (wr_ctrl)   ctrl_lo  <= writedata[3:0];
      if (wr_period) period_r <= writedata[PERIOD_W-1:0];
    end
  end
`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_c;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_c <= '0;
      duty  <= 4'hF;
    end else begin
      pwm_c <= pwm_c + 1'b1;
      if (wr_ctrl) duty <= writedata[7:4];
    end
  end
  assign pwm_on = (pwm_c < duty) || (duty == 4'hF);
`else
  assign duty   = 4'h0;
  assign pwm_on = 1'b1;
`endif
  assign readdata = (address == 2'd0) ? 32'(data_r) :
                    (address == 2'd1) ? {24'b0, duty, ctrl_lo} :
                    (address == 2'd2) ? 32'(period_r) : 32'(out_port);
endmodule
